// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: WIDTH-bit register with parallel load and one-bit-per-clock shift/rotate commands
module shift_reg_ctrl #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int AW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  localparam logic [2:0] LOAD = 3'd0, SHL = 3'd1, ROL = 3'd3, ROR = 3'd4;
  localparam logic [AW-1:0] WMAX = AW'(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [2:0] op_r, op_n;
  logic [AW-1:0] cnt, cnt_n, amt_c;
  logic [WIDTH-1:0] q_n, step;
  logic sout_n, done_n, left, out_bit;
  assign amt_c = (amount > WMAX) ? WMAX : amount;
  assign left = (op_r == SHL) || (op_r == ROL);
  assign step = left ? {q[WIDTH-2:0], (op_r == ROL) ? q[WIDTH-1] : sin}
                     : {(op_r == ROR) ? q[0] : sin, q[WIDTH-1:1]};
  assign out_bit = left ? q[WIDTH-1] : q[0];
  assign busy = (state == SHIFT);
  always_comb begin
    state_n = state;
    op_n = op_r;
    cnt_n = cnt;
    q_n = q;
    sout_n = sout;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        op_n = op;
        cnt_n = amt_c;
        if (op == LOAD) begin
          q_n = din;
          done_n = 1'b1;
        end else if (op > ROR || amt_c == '0) done_n = 1'b1;
        else state_n = SHIFT;
      end
    end else begin
      q_n = step;
      sout_n = out_bit;
      cnt_n = cnt - AW'(1);
      if (cnt == AW'(1)) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_r <= LOAD;
      cnt <= '0;
      q <= RESET_VAL;
      sout <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      op_r <= op_n;
      cnt <= cnt_n;
      q <= q_n;
      sout <= sout_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: randomized and directed stimulus checked every cycle against an arithmetic model
module tb_shift_reg_ctrl;
  logic clk = 0, reset = 1, start = 0, sin = 0;
  logic [2:0] op = 0;
  logic [3:0] amount = 0;
  logic [7:0] din = 0, q;
  logic sout, busy, done;
  int n_vec = 0, n_err = 0;
  int mq, ms, rem, mop, n, bc;
  bit mdone, ready = 0;

  shift_reg_ctrl dut (.clk(clk), .reset(reset), .start(start), .op(op), .amount(amount),
    .din(din), .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done));

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: remaining step count plus arithmetic shifts on an int-valued register
  always @(posedge clk) begin
    if (reset) begin
      mq = 0; ms = 0; rem = 0; mdone = 0; ready = 1;
    end else begin
      mdone = 0;
      if (rem > 0) begin
        case (mop)
          1: begin ms = (mq >> 7) & 1; mq = ((mq << 1) | sin) & 255; end
          2: begin ms = mq & 1; mq = (mq >> 1) | (sin << 7); end
          3: begin ms = (mq >> 7) & 1; mq = ((mq << 1) | ms) & 255; end
          default: begin ms = mq & 1; mq = (mq >> 1) | (ms << 7); end
        endcase
        rem--;
        mdone = (rem == 0);
      end else if (start) begin
        n = (amount > 8) ? 8 : amount;
        if (op == 0) begin mq = din; mdone = 1; end
        else if (op > 4 || n == 0) mdone = 1;
        else begin rem = n; mop = op; end
      end
    end
  end

  always @(negedge clk) if (ready) begin
    chk("q", q, mq);
    chk("sout", sout, ms);
    chk("busy", busy, rem > 0);
    chk("done", done, mdone);
  end

  task automatic cmd(input logic [2:0] o, input logic [3:0] a, input logic [7:0] d,
                     input logic s, input bit noisy, output int cnt);
    start = 1; op = o; amount = a; din = d; sin = s;
    @(negedge clk);
    start = 0; op = 3'($urandom); amount = 4'($urandom); din = 8'($urandom);
    cnt = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      cnt++;
      if (noisy) start = 1'($urandom);
      @(negedge clk);
    end
    start = 0;
    if (busy) chk("busy_timeout", busy, 0);
  endtask

  initial begin
    reset = 1; start = 1; op = 0; din = 8'hFF;
    repeat (2) @(negedge clk);
    reset = 0; start = 0;
    chk("reset_q", q, 0);
    chk("reset_model_q", mq, 0);
    cmd(3'd0, 0, 8'hA5, 0, 0, bc);
    chk("load_q", q, 8'hA5);
    chk("load_busy_cycles", bc, 0);
    cmd(3'd3, 3, 8'h00, 0, 0, bc);
    chk("rol_q", q, 8'h2D);
    chk("rol_sout", sout, 1);
    chk("rol_busy_cycles", bc, 3);
    chk("rol_model_q", mq, 8'h2D);
    cmd(3'd2, 2, 8'h00, 1, 1, bc);
    chk("shr_q", q, 8'hCB);
    chk("shr_sout", sout, 0);
    chk("shr_model_q", mq, 8'hCB);
    @(negedge clk);
    chk("shr_hold_q", q, 8'hCB);
    cmd(3'd1, 12, 8'h00, 0, 0, bc);
    chk("shl_q", q, 8'h00);
    chk("shl_busy_cycles", bc, 8);
    chk("shl_sout", sout, 1);
    cmd(3'd6, 5, 8'hFF, 1, 0, bc);
    chk("rsvd_q", q, 8'h00);
    chk("rsvd_done", done, 1);
    cmd(3'd0, 0, 8'h81, 0, 0, bc);
    start = 1; op = 3'd4; amount = 5;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_q", q, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    cmd(3'd0, 0, 8'h3C, 0, 0, bc);
    chk("reload_q", q, 8'h3C);
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      op = 3'($urandom_range(0, 7));
      amount = 4'($urandom);
      din = 8'($urandom);
      sin = 1'($urandom);
      reset = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    reset = 0; start = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
